// File: rtl/loader_pkg.sv
// loader_pkg: shared constants and FSM state encoding for the
// boot-time instruction-memory loader (imem_loader, word_packer).
package loader_pkg;

   localparam logic [7:0] SYNC_BYTE      = 8'hA5;
   localparam int         BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake, instruction-memory write bus
// and loader status. master = byte source/observer, slave = loader.
interface imem_loader_if #(
   parameter int ADDR_W = 6
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              load_done;
   logic              err;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata,
      input  cpu_rst, load_done, err
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata,
      output cpu_rst, load_done, err
   );
endinterface

// File: rtl/word_packer.sv
// word_packer: shifts bytes MSB-first into a 32-bit word. Ports: clk,
// rst (async low), clr_i, push_i, byte_i, last_o, word_o, word_ready_o.
module word_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic [7:0]  byte_i,
   output logic        last_o,
   output logic [31:0] word_o,
   output logic        word_ready_o
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  idx_q;
   logic [31:0] sreg_q;
   logic        rdy_q;

   assign last_o       = (idx_q == LAST_IDX);
   assign word_o       = sreg_q;
   assign word_ready_o = rdy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q  <= 2'd0;
         sreg_q <= 32'd0;
         rdy_q  <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         if (clr_i) begin
            idx_q  <= 2'd0;
            sreg_q <= 32'd0;
         end else if (push_i) begin
            sreg_q <= {sreg_q[23:0], byte_i};
            idx_q  <= idx_q + 2'd1;
            // one-cycle pulse in the cycle after the 4th byte
            rdy_q  <= last_o;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream into instruction memory and
// holds the core in reset until done. Ports: clk, rst (async low), bus.
// Define IMEM_LOADER_CSUM_EN to expect and verify a trailing checksum.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);

   localparam int CAP = 1 << ADDR_W;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] last_q;
   logic              rdy_q;
   logic              crst_q;
   logic              done_q;
   logic              err_q;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]        sum_q;
`endif

   logic        acc;
   logic        push;
   logic        clr;
   logic        is_sync;
   logic        cnt_ok;
   logic        byte_last;
   logic        wr;
   logic [31:0] word;

   assign acc     = bus.rx_valid & rdy_q;
   assign push    = acc & (state_q == S_DATA);
   assign clr     = acc & (state_q == S_COUNT);
   assign is_sync = (bus.rx_data == SYNC_BYTE);
   assign cnt_ok  = (bus.rx_data != 8'd0) &&
                    ({24'd0, bus.rx_data} <= 32'(CAP));

   word_packer u_pack (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr),
      .push_i       (push),
      .byte_i       (bus.rx_data),
      .last_o       (byte_last),
      .word_o       (word),
      .word_ready_o (wr)
   );

   assign bus.rx_ready   = rdy_q;
   assign bus.imem_we    = wr;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = word;
   assign bus.cpu_rst    = crst_q;
   assign bus.load_done  = done_q;
   assign bus.err        = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         last_q  <= '0;
         rdy_q   <= 1'b0;
         crst_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         sum_q   <= 8'd0;
`endif
      end else begin
         // stall the stream during the write cycle of each word
         rdy_q <= ~(push & byte_last);
         unique case (state_q)
            S_IDLE: begin
               if (acc && is_sync) state_q <= S_COUNT;
            end
            S_COUNT: begin
               if (acc) begin
                  if (cnt_ok) begin
                     last_q  <= ADDR_W'(bus.rx_data - 8'd1);
                     addr_q  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                     sum_q   <= 8'd0;
`endif
                     state_q <= S_DATA;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
            S_DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
               if (push) sum_q <= sum_q + bus.rx_data;
`endif
               if (wr) begin
                  // hold on the last address: no wrap at full capacity
                  if (addr_q == last_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                     state_q <= S_CSUM;
`else
                     state_q <= S_DONE;
                     crst_q  <= 1'b0;
                     done_q  <= 1'b1;
`endif
                  end else begin
                     addr_q <= addr_q + 1'b1;
                  end
               end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
               if (acc) begin
                  if (bus.rx_data == sum_q) begin
                     state_q <= S_DONE;
                     crst_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
`endif
            S_DONE: begin
               state_q <= S_DONE;
            end
            S_ERR: begin
               if (acc && is_sync) begin
                  err_q   <= 1'b0;
                  state_q <= S_COUNT;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
